// File: rtl/vc_credit_tx_if.sv
// vc_credit_tx_if: source handshake, downstream push and credit-return signals of one credited link.
interface vc_credit_tx_if #(
  parameter int LANES      = 2,
  parameter int DEPTH_BITS = 2,
  parameter int DATA_WIDTH = 32
);
  localparam int LANE_BITS = $clog2(LANES);
  logic [LANES-1:0]              src_valid;
  logic [LANES*DATA_WIDTH-1:0]   src_data;
  logic [LANES-1:0]              src_ready;
  logic                          push;
  logic [LANE_BITS-1:0]          push_lane;
  logic [DATA_WIDTH-1:0]         din;
  logic                          credit_ret;
  logic [LANE_BITS-1:0]          credit_lane;
  logic [LANES*(DEPTH_BITS+1)-1:0] credits;
  logic                          credit_err;
  modport master (
    input  src_valid, src_data, credit_ret, credit_lane,
    output src_ready, push, push_lane, din, credits, credit_err
  );
  modport slave (
    output src_valid, src_data, credit_ret, credit_lane,
    input  src_ready, push, push_lane, din, credits, credit_err
  );
endinterface

// File: rtl/vc_credit_tx.sv
// vc_credit_tx: credit-based round-robin transmitter feeding a downstream multilane FIFO.
module vc_credit_tx #(
  parameter int LANES      = 2,
  parameter int DEPTH_BITS = 2,
  parameter int DATA_WIDTH = 32
) (
  input logic          clk,
  input logic          reset,
  vc_credit_tx_if.master bus
);
  localparam int LANE_BITS = $clog2(LANES);
  localparam int CW = DEPTH_BITS + 1;
  localparam logic [CW-1:0] DEPTH = CW'(2**DEPTH_BITS);
  localparam logic [LANE_BITS:0] LANES_W = (LANE_BITS+1)'(LANES);
  localparam logic [LANE_BITS-1:0] LAST = LANE_BITS'(LANES - 1);
  logic [CW-1:0]         credit [LANES];
  logic [DATA_WIDTH-1:0] lane_data [LANES];
  logic [LANES-1:0]      elig, inc, dec;
  logic [LANE_BITS-1:0]  rr_ptr, g;
  logic [LANE_BITS:0]    idx;
  logic                  found, take;
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign lane_data[i] = bus.src_data[i*DATA_WIDTH +: DATA_WIDTH];
    assign elig[i] = bus.src_valid[i] & (credit[i] != '0);
    assign dec[i] = take && (g == LANE_BITS'(i));
    assign inc[i] = bus.credit_ret && (bus.credit_lane == LANE_BITS'(i));
    assign bus.credits[i*CW +: CW] = credit[i];
  end
  // First eligible lane at or after rr_ptr, wrapping modulo LANES.
  always_comb begin
    g = rr_ptr;
    found = 1'b0;
    idx = '0;
    for (int i = 0; i < LANES; i++) begin
      idx = {1'b0, rr_ptr} + (LANE_BITS+1)'(i);
      idx = idx >= LANES_W ? idx - LANES_W : idx;
      if (!found && elig[idx[LANE_BITS-1:0]]) begin
        found = 1'b1;
        g = idx[LANE_BITS-1:0];
      end
    end
    take = found & ~reset;
  end
  assign bus.src_ready = take ? LANES'(1) << g : '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int l = 0; l < LANES; l++) credit[l] <= DEPTH;
      bus.push       <= 1'b0;
      bus.push_lane  <= '0;
      bus.din        <= '0;
      bus.credit_err <= 1'b0;
      rr_ptr         <= '0;
    end else begin
      bus.push <= take;
      if (take) begin
        bus.push_lane <= g;
        bus.din       <= lane_data[g];
        rr_ptr        <= g == LAST ? '0 : g + 1'b1;
      end
      // A same-lane return and grant cancel out; a lone return to a full lane saturates and flags.
      for (int l = 0; l < LANES; l++) begin
        if (inc[l] && !dec[l]) begin
          if (credit[l] == DEPTH) bus.credit_err <= 1'b1;
          else credit[l] <= credit[l] + 1'b1;
        end else if (dec[l] && !inc[l]) begin
          credit[l] <= credit[l] - 1'b1;
        end
      end
    end
  end
endmodule
